// File: rtl/ahb_mem_responder.sv
// ahb_mem_responder
//   AHB-Lite slave backed by an internal word-addressed memory. Accepts
//   NONSEQ/SEQ address phases, inserts WAIT wait states per data phase,
//   performs little-endian byte-lane reads/writes and answers with OKAY or a
//   two-cycle ERROR (oversized or misaligned transfers).
//
// Parameters
//   DW         data width, 32 or 64
//   AW         address width (>= 8)
//   DEPTH_LOG2 memory holds 2^DEPTH_LOG2 words of DW bits
//   WAIT       wait states per data phase, 0..15
//
// Ports
//   hclk      in   clock, rising edge
//   hreset    in   asynchronous active-high reset
//   hsel      in   slave select
//   haddr     in   transfer address
//   htrans    in   IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   hsize     in   transfer size, bytes = 2^hsize
//   hwrite    in   1=write, 0=read
//   hwdata    in   write data (sampled in the DATA cycle only)
//   hready_i  in   bus HREADY, qualifies the address phase
//   hrdata    out  registered read data
//   hready_o  out  slave ready
//   hresp     out  0=OKAY, 1=ERROR
module ahb_mem_responder #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT       = 0
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic [2:0]    hsize,
    input  logic          hwrite,
    input  logic [DW-1:0] hwdata,
    input  logic          hready_i,
    output logic [DW-1:0] hrdata,
    output logic          hready_o,
    output logic          hresp
);

    localparam int unsigned NB    = DW / 8;
    localparam int unsigned LB    = $clog2(NB);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0]  WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAITING,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              wcnt_q, wcnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [NB-1:0]           mask_q, mask_d;
    logic                    write_q, write_d;
    logic [DW-1:0]           hrdata_q, hrdata_d;
    logic [DW-1:0]           mem_q [DEPTH];

    // Address-phase decode
    logic                    accept;
    logic [DEPTH_LOG2-1:0]   ap_idx;
    logic [LB-1:0]           ap_off;
    logic [NB-1:0]           ap_mask;
    logic [7:0]              ap_amask;
    logic                    ap_err;

    // Data-phase helpers
    logic                    commit;
    logic                    fetch;
    logic [DEPTH_LOG2-1:0]   fetch_idx;
    logic [DW-1:0]           fetch_word;

    logic                    unused_ok;
    assign unused_ok = ^{htrans[0], haddr};

    // hready_o is part of the qualifier so an address phase can never be
    // taken while this slave is still stalling its own data phase.
    assign accept   = hsel & htrans[1] & hready_i & hready_o;
    assign ap_idx   = haddr[LB +: DEPTH_LOG2];
    assign ap_off   = haddr[LB-1:0];
    assign ap_amask = (8'd1 << hsize) - 8'd1;
    assign ap_err   = (hsize > 3'(LB)) | (|(haddr[7:0] & ap_amask));

    always_comb begin
        ap_mask = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            ap_mask[b] = (b >= 32'(ap_off)) && ((b - 32'(ap_off)) < (32'd1 << hsize));
        end
    end

    assign commit = (state_q == ST_DATA) & write_q;

    // Read fetch happens on the edge that enters the final data-phase cycle:
    // the accept edge itself when there are no wait states, otherwise the
    // edge leaving the last WAITING cycle.
    always_comb begin
        fetch     = 1'b0;
        fetch_idx = ap_idx;
        if (state_q == ST_WAITING) begin
            fetch_idx = idx_q;
            fetch     = (wcnt_q == 4'd0) & ~write_q;
        end else begin
            fetch     = accept & ~ap_err & ~hwrite & (WAIT == 0);
        end
    end

    // Forward lanes of a write committing on the same edge as the fetch.
    always_comb begin
        fetch_word = mem_q[fetch_idx];
        if (commit && (idx_q == fetch_idx)) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (mask_q[b]) begin
                    fetch_word[8*b +: 8] = hwdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        hrdata_d = hrdata_q;
        if (fetch) begin
            hrdata_d = fetch_word;
        end
    end

    // State register
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= '0;
            idx_q    <= '0;
            mask_q   <= '0;
            write_q  <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            write_q  <= write_d;
            hrdata_q <= hrdata_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        write_d = write_q;
        unique case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept) begin
                    idx_d   = ap_idx;
                    mask_d  = ap_mask;
                    write_d = hwrite & ~ap_err;
                    if (ap_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT > 0) begin
                        state_d = ST_WAITING;
                        wcnt_d  = WAIT_M1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_WAITING: begin
                if (wcnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        hready_o = 1'b1;
        hresp    = 1'b0;
        unique case (state_q)
            ST_WAITING: hready_o = 1'b0;
            ST_ERR1: begin
                hready_o = 1'b0;
                hresp    = 1'b1;
            end
            ST_ERR2: hresp = 1'b1;
            default: ;
        endcase
    end

    assign hrdata = hrdata_q;

    // Memory array is never reset; a write still pending when reset hits
    // must not land, hence the explicit hreset gate.
    always_ff @(posedge hclk) begin
        if (commit && !hreset) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (mask_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_mem_responder.sv
module tb_ahb_mem_responder;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [2:0]  hsel_v;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hri_en;

    logic [31:0] rd0, rd3, rd2;
    logic        rdy0, rdy3, rdy2;
    logic        rsp0, rsp3, rsp2;
    logic        hri0, hri3, hri2;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 hclk = ~hclk;

    assign hri0 = rdy0 & hri_en;
    assign hri3 = rdy3 & hri_en;
    assign hri2 = rdy2 & hri_en;

    ahb_mem_responder #(.DW(32), .AW(32), .DEPTH_LOG2(10), .WAIT(0)) u_w0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_v[0]), .haddr(haddr),
        .htrans(htrans), .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata),
        .hready_i(hri0), .hrdata(rd0), .hready_o(rdy0), .hresp(rsp0)
    );

    ahb_mem_responder #(.DW(32), .AW(32), .DEPTH_LOG2(10), .WAIT(3)) u_w3 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_v[1]), .haddr(haddr),
        .htrans(htrans), .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata),
        .hready_i(hri3), .hrdata(rd3), .hready_o(rdy3), .hresp(rsp3)
    );

    ahb_mem_responder #(.DW(32), .AW(32), .DEPTH_LOG2(10), .WAIT(2)) u_w2 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_v[2]), .haddr(haddr),
        .htrans(htrans), .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata),
        .hready_i(hri2), .hrdata(rd2), .hready_o(rdy2), .hresp(rsp2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic ap(input int unsigned d, input logic [31:0] a, input logic [2:0] s, input logic w);
        hsel_v    = '0;
        hsel_v[d] = 1'b1;
        haddr     = a;
        hsize     = s;
        hwrite    = w;
        htrans    = 2'b10;
    endtask

    task automatic idle();
        hsel_v = '0;
        htrans = 2'b00;
        haddr  = '0;
        hsize  = '0;
        hwrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        idle();
        hwdata = '0;
        hri_en = 1'b1;
        hreset = 1'b1;
        repeat (3) @(posedge hclk);
        #1 hreset = 1'b0;

        // Reset state
        check("rst rd0", rd0, 32'h0);
        check("rst rdy0", rdy0, 1);
        check("rst rsp0", rsp0, 0);
        check("rst rd3", rd3, 32'h0);
        check("rst rdy3", rdy3, 1);

        // WAIT=0 word write then read
        ap(0, 32'h10, 3'd2, 1'b1); tick();
        check("w0 wr rdy", rdy0, 1);
        hwdata = 32'hDEADBEEF; idle(); tick();
        ap(0, 32'h10, 3'd2, 1'b0); tick();
        check("w0 rd data", rd0, 32'hDEADBEEF);
        check("w0 rd rdy", rdy0, 1);
        check("w0 rd resp", rsp0, 0);

        // Byte / halfword lanes
        ap(0, 32'h20, 3'd2, 1'b1); tick();
        hwdata = 32'h0000_0000; ap(0, 32'h21, 3'd0, 1'b1); tick();
        hwdata = 32'h0000_AA00; ap(0, 32'h22, 3'd1, 1'b1); tick();
        hwdata = 32'h1234_0000; idle(); tick();
        ap(0, 32'h20, 3'd2, 1'b0); tick();
        check("lanes rd", rd0, 32'h1234AA00);

        // Back-to-back pipelined reads
        ap(0, 32'h10, 3'd2, 1'b0); tick();
        check("b2b rd1", rd0, 32'hDEADBEEF);
        check("b2b rdy1", rdy0, 1);
        ap(0, 32'h20, 3'd2, 1'b0); tick();
        check("b2b rd2", rd0, 32'h1234AA00);
        check("b2b rdy2", rdy0, 1);

        // Write-read forwarding
        ap(0, 32'h40, 3'd2, 1'b1); tick();
        hwdata = 32'h11111111; ap(0, 32'h40, 3'd2, 1'b1); tick();
        hwdata = 32'hCAFEF00D; ap(0, 32'h40, 3'd2, 1'b0); tick();
        check("fwd word", rd0, 32'hCAFEF00D);
        ap(0, 32'h41, 3'd0, 1'b1); tick();
        hwdata = 32'h0000_7700; ap(0, 32'h40, 3'd2, 1'b0); tick();
        check("fwd byte", rd0, 32'hCAFE770D);
        idle(); tick();

        // Address phase with hready_i low is ignored
        hri_en = 1'b0;
        ap(0, 32'h10, 3'd2, 1'b0); tick();
        check("hri low hold", rd0, 32'hCAFE770D);
        hri_en = 1'b1;
        idle(); tick();

        // IDLE transfer with a misaligned address is not captured
        hsel_v = 3'b001; htrans = 2'b00; haddr = 32'h31; hsize = 3'd1; tick();
        check("idle trans resp", rsp0, 0);
        idle();

        // Error responses
        ap(0, 32'h30, 3'd2, 1'b1); tick();
        hwdata = 32'h55667788; ap(0, 32'h31, 3'd1, 1'b1); tick();
        check("err1 rdy", rdy0, 0);
        check("err1 resp", rsp0, 1);
        hwdata = 32'hFFFFFFFF; idle(); tick();
        check("err2 rdy", rdy0, 1);
        check("err2 resp", rsp0, 1);
        tick();
        check("err done resp", rsp0, 0);
        ap(0, 32'h30, 3'd3, 1'b0); tick();
        check("size err1 rdy", rdy0, 0);
        check("size err1 resp", rsp0, 1);
        idle(); tick();
        check("size err2 rdy", rdy0, 1);
        check("size err2 resp", rsp0, 1);
        check("size err rd hold", rd0, 32'hCAFE770D);
        tick();
        ap(0, 32'h30, 3'd2, 1'b0); tick();
        check("err mem kept", rd0, 32'h55667788);
        idle(); tick();

        // WAIT=3 write: hwdata during wait states must be ignored
        ap(1, 32'h50, 3'd2, 1'b1); tick();
        check("w3 wr wait0", rdy3, 0);
        hwdata = 32'hFFFFFFFF; idle();
        for (int i = 1; i < 3; i++) begin
            tick();
            check($sformatf("w3 wr wait%0d", i), rdy3, 0);
        end
        tick();
        check("w3 wr data rdy", rdy3, 1);
        hwdata = 32'h0BADF00D; tick();
        check("w3 wr done rdy", rdy3, 1);

        // WAIT=3 read: three low cycles, hrdata held until the data cycle
        ap(1, 32'h50, 3'd2, 1'b0); tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("w3 rd wait%0d", i), rdy3, 0);
            check($sformatf("w3 rd hold%0d", i), rd3, 32'h0);
            tick();
        end
        check("w3 rd rdy", rdy3, 1);
        check("w3 rd data", rd3, 32'h0BADF00D);
        check("w3 rd resp", rsp3, 0);
        tick();

        // Error length independent of WAIT
        ap(1, 32'h52, 3'd2, 1'b0); tick();
        check("w3 err1 rdy", rdy3, 0);
        check("w3 err1 resp", rsp3, 1);
        idle(); tick();
        check("w3 err2 rdy", rdy3, 1);
        check("w3 err2 resp", rsp3, 1);
        tick();
        check("w3 err done", rsp3, 0);

        // WAIT=2: preload, read back, then reset during a write's wait state
        ap(2, 32'h60, 3'd2, 1'b1); tick();
        hwdata = 32'hFFFFFFFF; idle(); tick(); tick();
        check("w2 wr data rdy", rdy2, 1);
        hwdata = 32'h13579BDF; tick();
        ap(2, 32'h60, 3'd2, 1'b0); tick();
        idle(); tick(); tick();
        check("w2 rd data", rd2, 32'h13579BDF);
        check("w2 rd rdy", rdy2, 1);
        tick();
        ap(2, 32'h60, 3'd2, 1'b1); tick();
        check("w2 wr2 wait", rdy2, 0);
        hwdata = 32'hFFFFFFFF; idle();
        #2 hreset = 1'b1;
        #1;
        check("rst mid rdy", rdy2, 1);
        check("rst mid resp", rsp2, 0);
        check("rst mid rd", rd2, 32'h0);
        @(posedge hclk);
        #1 hreset = 1'b0;
        ap(2, 32'h60, 3'd2, 1'b0); tick();
        idle(); tick(); tick();
        check("rst abort rdy", rdy2, 1);
        check("rst abort mem", rd2, 32'h13579BDF);
        check("rst rd0 after", rd0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
